// File: rtl/calc_pkg.sv
// Shared definitions for the calculator issuer: opcodes, FSM states, request payload.
package calc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_MUL = 2'd2;
  localparam logic [OP_W-1:0] OP_SQR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_SEND_OP,
    ST_SEND_B,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Operands latched at the request handshake
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] b;
  } req_t;

endpackage

// File: rtl/calc_issuer.sv
// Serialises one request (A, op, B) to the byte-stream calculator, waits for the
// result and holds it for the consumer; counts completed transactions.
import calc_pkg::*;

module calc_issuer #(
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_b,
  output logic              calc_valid,
  output logic [DATA_W-1:0] calc_data,
  input  logic [DATA_W-1:0] calc_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [7:0]        txn_count
);

  // A zero-cycle result latency cannot be scheduled; refuse to elaborate
  if (RESULT_LAT == 0) begin : g_bad_lat
    $error("calc_issuer: RESULT_LAT must be at least 1");
  end

  localparam int unsigned CNT_W = (RESULT_LAT == 0) ? 1 : $clog2(RESULT_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_LAT - 1);

  state_t            state_q, state_d;
  req_t              opnd_q, opnd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_d;
  logic              calc_valid_d;
  logic [DATA_W-1:0] calc_data_d;
  logic              resp_valid_d;
  logic [DATA_W-1:0] resp_data_d;
  logic [7:0]        txn_count_d;

  // Next-state and next-output decode; outputs are registered alongside the state
  always_comb begin
    state_d      = state_q;
    opnd_d       = opnd_q;
    cnt_d        = cnt_q;
    calc_valid_d = 1'b0;
    calc_data_d  = '0;
    resp_data_d  = resp_data;
    txn_count_d  = txn_count;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d      = ST_SEND_A;
          opnd_d       = '{a: req_a, op: req_op, b: req_b};
          calc_valid_d = 1'b1;
          calc_data_d  = req_a;
        end
      end
      ST_SEND_A: begin
        state_d      = ST_SEND_OP;
        calc_valid_d = 1'b1;
        calc_data_d  = DATA_W'(opnd_q.op);
      end
      ST_SEND_OP: begin
        state_d      = ST_SEND_B;
        calc_valid_d = 1'b1;
        calc_data_d  = (opnd_q.op == OP_SQR) ? '0 : opnd_q.b;
      end
      ST_SEND_B: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          cnt_d       = '0;
          resp_data_d = calc_out;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d     = ST_IDLE;
          txn_count_d = txn_count + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      opnd_q     <= '0;
      cnt_q      <= '0;
      req_ready  <= 1'b1;
      calc_valid <= 1'b0;
      calc_data  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      txn_count  <= '0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      req_ready  <= req_ready_d;
      calc_valid <= calc_valid_d;
      calc_data  <= calc_data_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      txn_count  <= txn_count_d;
    end
  end

endmodule

// File: tb/tb_calc_issuer.sv
// Directed bench for calc_issuer with a behavioural byte-stream calculator.
module tb_calc_issuer;

  localparam int unsigned LAT = 1;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [1:0] req_op;
  logic [7:0] req_b;
  logic       calc_valid;
  logic [7:0] calc_data;
  logic [7:0] calc_out;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic [7:0] txn_count;

  int         n_vec;
  int         n_bad;
  logic [7:0] exp_txn;

  calc_issuer #(.RESULT_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_op     (req_op),
    .req_b      (req_b),
    .calc_valid (calc_valid),
    .calc_data  (calc_data),
    .calc_out   (calc_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .txn_count  (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator: gathers A, op, B and presents the 8-bit result one cycle after B
  logic [1:0] bcnt;
  logic [7:0] ca;
  logic [1:0] cop;

  function automatic logic [7:0] calc_fn(input logic [7:0] a, input logic [1:0] op,
                                         input logic [7:0] b);
    logic [7:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a * b;
      default: r = a * a;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt     <= 2'd0;
      ca       <= 8'd0;
      cop      <= 2'd0;
      calc_out <= 8'd0;
    end else if (calc_valid) begin
      case (bcnt)
        2'd0: begin ca <= calc_data; bcnt <= 2'd1; end
        2'd1: begin cop <= calc_data[1:0]; bcnt <= 2'd2; end
        default: begin calc_out <= calc_fn(ca, cop, calc_data); bcnt <= 2'd0; end
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One full transaction; hold = cycles of resp_ready=0 in RESP (0 keeps it high throughout)
  task automatic run_txn(input logic [7:0] a, input logic [1:0] op, input logic [7:0] b,
                         input logic [7:0] res, input int hold);
    for (int i = 0; i < 20 && !req_ready; i++) cyc();
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_a      = a;
    req_op     = op;
    req_b      = b;
    resp_ready = (hold == 0);
    cyc();
    req_valid = 1'b0;
    req_a     = ~a;
    req_op    = op ^ 2'd1;
    req_b     = ~b;
    chk("send_a_valid", 32'(calc_valid), 32'd1);
    chk("send_a_data", 32'(calc_data), 32'(a));
    chk("busy_req_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("send_op_valid", 32'(calc_valid), 32'd1);
    chk("send_op_data", 32'(calc_data), 32'(op));
    cyc();
    chk("send_b_valid", 32'(calc_valid), 32'd1);
    chk("send_b_data", 32'(calc_data), (op == 2'd3) ? 32'd0 : 32'(b));
    chk("send_b_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < int'(LAT); i++) begin
      cyc();
      chk("wait_valid", 32'(calc_valid), 32'd0);
      chk("wait_data", 32'(calc_data), 32'd0);
      chk("wait_resp_valid", 32'(resp_valid), 32'd0);
      chk("wait_txn", 32'(txn_count), 32'(exp_txn));
    end
    cyc();
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_data", 32'(resp_data), 32'(res));
    chk("resp_calc_valid", 32'(calc_valid), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      cyc();
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_data", 32'(resp_data), 32'(res));
      chk("bp_calc_valid", 32'(calc_valid), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_txn", 32'(txn_count), 32'(exp_txn));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    cyc();
    resp_ready = 1'b0;
    exp_txn    = exp_txn + 8'd1;
    chk("done_resp_valid", 32'(resp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
    chk("done_txn", 32'(txn_count), 32'(exp_txn));
  endtask

  typedef struct {
    logic [7:0] a;
    logic [1:0] op;
    logic [7:0] b;
    logic [7:0] res;
    int         hold;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd5,   2'd0, 8'd4,   8'd9,   0};  // add
    vecs[1] = '{8'd10,  2'd1, 8'd3,   8'd7,   0};  // sub
    vecs[2] = '{8'd4,   2'd2, 8'd3,   8'd12,  0};  // mul
    vecs[3] = '{8'd2,   2'd3, 8'hFF,  8'd4,   0};  // square, B ignored
    vecs[4] = '{8'd200, 2'd0, 8'd100, 8'd44,  6};  // add wrap + backpressure
    vecs[5] = '{8'd3,   2'd1, 8'd5,   8'hFE,  2};  // sub wrap
    vecs[6] = '{8'd16,  2'd2, 8'd17,  8'h10,  0};  // mul wrap
    vecs[7] = '{8'd16,  2'd3, 8'd7,   8'd0,   0};  // square wrap

    n_vec      = 0;
    n_bad      = 0;
    exp_txn    = 8'd0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_a      = 8'd0;
    req_op     = 2'd0;
    req_b      = 8'd0;
    resp_ready = 1'b0;

    #12;
    chk("rst_calc_valid", 32'(calc_valid), 32'd0);
    chk("rst_calc_data", 32'(calc_data), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    rst = 1'b1;
    cyc();
    chk("rel_req_ready", 32'(req_ready), 32'd1);
    chk("rel_resp_data", 32'(resp_data), 32'd0);

    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].a, vecs[i].op, vecs[i].b, vecs[i].res, vecs[i].hold);

    // Reset while the opcode byte is on the bus
    req_valid = 1'b1;
    req_a     = 8'd5;
    req_op    = 2'd1;
    req_b     = 8'd4;
    cyc();
    req_valid = 1'b0;
    cyc();
    chk("mid_send_op_valid", 32'(calc_valid), 32'd1);
    chk("mid_send_op_data", 32'(calc_data), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_calc_valid", 32'(calc_valid), 32'd0);
    chk("mid_rst_calc_data", 32'(calc_data), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_resp_data", 32'(resp_data), 32'd0);
    chk("mid_rst_txn", 32'(txn_count), 32'd0);
    #2;
    rst     = 1'b1;
    exp_txn = 8'd0;
    cyc();
    chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rel_calc_valid", 32'(calc_valid), 32'd0);
    chk("mid_rel_resp_valid", 32'(resp_valid), 32'd0);
    run_txn(8'd1, 2'd0, 8'd1, 8'd2, 0);

    // Drive the counter round to 256 completions
    for (int i = 0; i < 255; i++)
      run_txn(8'(i), 2'd0, 8'd1, 8'(i + 1), 0);
    chk("txn_wrap", 32'(txn_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
